// File: rtl/fifo_pkg.sv
// fifo_pkg: Gray/binary pointer helpers shared by both FIFO clock domains.
package fifo_pkg;
  localparam int ADDR_WIDTH_DEF = 3;
  localparam int PTR_W = ADDR_WIDTH_DEF + 1;
  localparam int MAX_W = 32;
  // Callers zero-extend into MAX_W bits and slice the result, so any width up to MAX_W works.
  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/fifo_out_reg.sv
// fifo_out_reg: first-word-fall-through VALID/READY output register with refill decision.
module fifo_out_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  empty_i,
  input  logic                  ready_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  load_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o
);
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  always_comb begin
    load_o  = !empty_i && (!valid_q || ready_i);
    valid_d = load_o || (valid_q && !ready_i);
    data_d  = load_o ? data_i : data_q;
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: rtl/read_empty_ctrl.sv
// read_empty_ctrl: async FIFO read side -- read pointer, EMPTY, fill level and FWFT output.
module read_empty_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH:0]   W_PTR_SYNC,
  input  logic [DATA_WIDTH-1:0] MEM_RD_DATA,
  input  logic                  RD_READY,
  output logic [ADDR_WIDTH-1:0] R_ADDR,
  output logic                  MEM_R_EN,
  output logic [ADDR_WIDTH:0]   R_PTR,
  output logic                  EMPTY,
  output logic                  RD_VALID,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic [ADDR_WIDTH:0]   R_LEVEL
);
  localparam int PW = ADDR_WIDTH + 1;
  logic [PW-1:0] r_bin_q, r_bin_d, r_ptr_q, r_ptr_d, r_inc, w_bin;
  logic          load;
  always_comb begin
    r_inc   = r_bin_q + 1'b1;
    r_bin_d = load ? r_inc : r_bin_q;
    r_ptr_d = load ? PW'(bin2gray(MAX_W'(r_inc))) : r_ptr_q;
    w_bin   = PW'(gray2bin(MAX_W'(W_PTR_SYNC)));
  end
  // R_PTR crosses clock domains, so it comes straight from a flop.
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      r_bin_q <= '0;
      r_ptr_q <= '0;
    end else begin
      r_bin_q <= r_bin_d;
      r_ptr_q <= r_ptr_d;
    end
  fifo_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out (
    .CLK     (CLK),
    .RST     (RST),
    .empty_i (EMPTY),
    .ready_i (RD_READY),
    .data_i  (MEM_RD_DATA),
    .load_o  (load),
    .valid_o (RD_VALID),
    .data_o  (RD_DATA)
  );
  assign EMPTY    = r_ptr_q == W_PTR_SYNC;
  assign MEM_R_EN = load;
  assign R_PTR    = r_ptr_q;
  assign R_ADDR   = r_bin_q[ADDR_WIDTH-1:0];
  assign R_LEVEL  = w_bin - r_bin_q;
endmodule

// File: tb/tb_read_empty_ctrl.sv
// tb_read_empty_ctrl: directed checks of read_empty_ctrl with hand-computed expectations.
module tb_read_empty_ctrl;
  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] W_PTR_SYNC;
  logic [7:0] MEM_RD_DATA;
  logic       RD_READY;
  logic [2:0] R_ADDR;
  logic       MEM_R_EN;
  logic [3:0] R_PTR;
  logic       EMPTY;
  logic       RD_VALID;
  logic [7:0] RD_DATA;
  logic [3:0] R_LEVEL;
  logic [7:0] mem [8];
  int checks = 0;
  int errors = 0;

  read_empty_ctrl #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .W_PTR_SYNC  (W_PTR_SYNC),
    .MEM_RD_DATA (MEM_RD_DATA),
    .RD_READY    (RD_READY),
    .R_ADDR      (R_ADDR),
    .MEM_R_EN    (MEM_R_EN),
    .R_PTR       (R_PTR),
    .EMPTY       (EMPTY),
    .RD_VALID    (RD_VALID),
    .RD_DATA     (RD_DATA),
    .R_LEVEL     (R_LEVEL)
  );

  always #5 CLK = ~CLK;
  assign MEM_RD_DATA = mem[R_ADDR];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  logic rdy_seq [5] = '{1, 0, 1, 1, 1};
  logic men_seq [5] = '{1, 0, 1, 1, 0};
  logic val_seq [5] = '{1, 1, 1, 1, 0};
  logic [7:0] dat_seq [5] = '{8'h20, 8'h20, 8'h21, 8'h22, 8'h22};

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'h10 + 8'(i);
    mem[0] = 8'hA5;
    RST = 1'b0;
    W_PTR_SYNC = 4'b0000;
    RD_READY = 1'b0;
    #3;
    chk("rst_empty", EMPTY, 1);
    chk("rst_valid", RD_VALID, 0);
    chk("rst_rptr", R_PTR, 0);
    chk("rst_level", R_LEVEL, 0);
    chk("rst_men", MEM_R_EN, 0);
    chk("rst_data", RD_DATA, 0);
    @(negedge CLK);
    RST = 1'b1;
    // single word with consumer stalled
    W_PTR_SYNC = 4'b0001;
    #1;
    chk("one_men_pre", MEM_R_EN, 1);
    chk("one_level_pre", R_LEVEL, 1);
    chk("one_empty_pre", EMPTY, 0);
    step();
    chk("one_valid", RD_VALID, 1);
    chk("one_data", RD_DATA, 8'hA5);
    chk("one_rptr", R_PTR, 4'b0001);
    chk("one_empty", EMPTY, 1);
    chk("one_level", R_LEVEL, 0);
    chk("one_men_post", MEM_R_EN, 0);
    step();
    chk("hold_data", RD_DATA, 8'hA5);
    chk("hold_valid", RD_VALID, 1);
    chk("hold_men", MEM_R_EN, 0);
    // burst: writer at 8 (gray 1100), reader at 1, consumer always ready
    W_PTR_SYNC = 4'b1100;
    RD_READY = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      #1;
      chk("burst_level", R_LEVEL, 32'(8 - k));
      chk("burst_men", MEM_R_EN, 1);
      chk("burst_addr", R_ADDR, 32'(k));
      step();
      chk("burst_data", RD_DATA, 32'(8'h10 + 8'(k)));
      chk("burst_valid", RD_VALID, 1);
    end
    chk("burst_rptr", R_PTR, 4'b1100);
    chk("burst_empty", EMPTY, 1);
    chk("burst_men_end", MEM_R_EN, 0);
    step();
    chk("burst_valid_drop", RD_VALID, 0);
    chk("burst_data_hold", RD_DATA, 8'h17);
    // back-pressure: writer at 11 (gray 1110), reader at 8
    mem[0] = 8'h20;
    mem[1] = 8'h21;
    mem[2] = 8'h22;
    W_PTR_SYNC = 4'b1110;
    for (int k = 0; k < 5; k++) begin
      RD_READY = rdy_seq[k];
      #1;
      chk("bp_men", MEM_R_EN, 32'(men_seq[k]));
      step();
      chk("bp_valid", RD_VALID, 32'(val_seq[k]));
      chk("bp_data", RD_DATA, 32'(dat_seq[k]));
    end
    chk("bp_rptr", R_PTR, 4'b1110);
    chk("bp_empty", EMPTY, 1);
    // advance reader 11 -> 15 (writer gray(15) = 1000)
    W_PTR_SYNC = 4'b1000;
    #1;
    chk("pre_wrap_level", R_LEVEL, 4);
    repeat (4) step();
    chk("pre_wrap_rptr", R_PTR, 4'b1000);
    chk("pre_wrap_empty", EMPTY, 1);
    chk("pre_wrap_data", RD_DATA, 8'h16);
    step();
    chk("pre_wrap_valid", RD_VALID, 0);
    // writer wraps to 1: level = 1 - 15 mod 16 = 2
    W_PTR_SYNC = 4'b0001;
    #1;
    chk("wrap_level", R_LEVEL, 2);
    chk("wrap_empty_pre", EMPTY, 0);
    chk("wrap_addr", R_ADDR, 7);
    step();
    chk("wrap_rptr0", R_PTR, 4'b0000);
    chk("wrap_level1", R_LEVEL, 1);
    chk("wrap_data0", RD_DATA, 8'h17);
    step();
    chk("wrap_rptr1", R_PTR, 4'b0001);
    chk("wrap_empty", EMPTY, 1);
    chk("wrap_level0", R_LEVEL, 0);
    chk("wrap_data1", RD_DATA, 8'h20);
    chk("wrap_valid", RD_VALID, 1);
    // asynchronous reset mid-cycle with a word held
    RD_READY = 1'b0;
    #2;
    RST = 1'b0;
    #1;
    chk("arst_valid", RD_VALID, 0);
    chk("arst_rptr", R_PTR, 0);
    chk("arst_data", RD_DATA, 0);
    chk("arst_level", R_LEVEL, 1);
    chk("arst_empty", EMPTY, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
